// File: rtl/counter_seq_ctrl_pkg.sv
// ============================================================================
// counter_seq_ctrl_pkg : state encoding and default sizes for counter_seq_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package counter_seq_ctrl_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_RPT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      HOLD = ST_HOLD,
      DONE = ST_DONE
   } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_seq_core.sv
// ============================================================================
// counter_seq_core : WIDTH-bit up/down counter register (clr > load > en)
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_seq_core
   import counter_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = up ? (count_q + 1'b1) : (count_q - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ============================================================================
// counter_seq_ctrl : start/pause/stop sequencer for a bounded multi-pass counter
// Optional down counting with `define COUNTER_SEQ_CTRL_DIR_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int RPT_W = DEF_RPT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] limit,
   input  logic [RPT_W-1:0] repeats,
`ifdef COUNTER_SEQ_CTRL_DIR_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] count,
   output logic [RPT_W-1:0] pass_cnt,
   output logic             busy,
   output logic             wrap,
   output logic             done,
   output logic [1:0]       state
);

   state_e           state_d,    state_q;
   logic [RPT_W-1:0] pass_cnt_d, pass_cnt_q;
   logic [WIDTH-1:0] limit_d,    limit_q;
   logic [RPT_W-1:0] repeats_d,  repeats_q;
   logic             busy_d,     busy_q;
   logic             wrap_d,     wrap_q;
   logic             done_d,     done_q;
`ifdef COUNTER_SEQ_CTRL_DIR_EN
   logic             dir_d,      dir_q;
`endif

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_load;
   logic [WIDTH-1:0] cnt_load_val;
   logic             cnt_up;
   logic             step;
   logic             term;
   logic [RPT_W-1:0] pass_inc;
   logic [WIDTH-1:0] count_cur;

`ifdef COUNTER_SEQ_CTRL_DIR_EN
   assign cnt_up = ~dir_q;
   assign term   = dir_q ? (count_cur == '0) : (count_cur == limit_q);
`else
   assign cnt_up = 1'b1;
   assign term   = (count_cur == limit_q);
`endif

   assign pass_inc = pass_cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      pass_cnt_d   = pass_cnt_q;
      limit_d      = limit_q;
      repeats_d    = repeats_q;
`ifdef COUNTER_SEQ_CTRL_DIR_EN
      dir_d        = dir_q;
`endif
      wrap_d       = 1'b0;
      done_d       = 1'b0;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      step         = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (!stop && start) begin
               state_d    = RUN;
               limit_d    = limit;
               repeats_d  = repeats;
               pass_cnt_d = '0;
`ifdef COUNTER_SEQ_CTRL_DIR_EN
               dir_d = dir;
               if (dir) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = limit;
               end else begin
                  cnt_clr = 1'b1;
               end
`else
               cnt_clr = 1'b1;
`endif
            end else begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d    = IDLE;
               cnt_clr    = 1'b1;
               pass_cnt_d = '0;
            end else if (pause) begin
               state_d = HOLD;
            end else begin
               step = 1'b1;
            end
         end
         HOLD: begin
            if (stop) begin
               state_d    = IDLE;
               cnt_clr    = 1'b1;
               pass_cnt_d = '0;
            end else if (!pause) begin
               // the edge that sees pause low already counts
               state_d = RUN;
               step    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_clr = 1'b1;
         end
      endcase

      if (step) begin
         if (term) begin
            wrap_d     = 1'b1;
            pass_cnt_d = pass_inc;
`ifdef COUNTER_SEQ_CTRL_DIR_EN
            if (dir_q) begin
               cnt_load     = 1'b1;
               cnt_load_val = limit_q;
            end else begin
               cnt_clr = 1'b1;
            end
`else
            cnt_clr = 1'b1;
`endif
            if ((repeats_q != '0) && (pass_inc == repeats_q)) begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end else begin
            cnt_en = 1'b1;
         end
      end

      busy_d = (state_d == RUN) || (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pass_cnt_q <= '0;
         limit_q    <= '0;
         repeats_q  <= '0;
         busy_q     <= 1'b0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef COUNTER_SEQ_CTRL_DIR_EN
         dir_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pass_cnt_q <= pass_cnt_d;
         limit_q    <= limit_d;
         repeats_q  <= repeats_d;
         busy_q     <= busy_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
`ifdef COUNTER_SEQ_CTRL_DIR_EN
         dir_q      <= dir_d;
`endif
      end
   end

   counter_seq_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .up       (cnt_up),
      .count    (count_cur)
   );

   assign count    = count_cur;
   assign pass_cnt = pass_cnt_q;
   assign busy     = busy_q;
   assign wrap     = wrap_q;
   assign done     = done_q;
   assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
// ============================================================================
// tb_counter_seq_ctrl : directed vector table plus corner-case sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, pause;
   logic [3:0] limit, repeats;
   logic       dir;
   logic [3:0] count, pass_cnt;
   logic       busy, wrap, done;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(4), .RPT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .limit    (limit),
      .repeats  (repeats),
`ifdef COUNTER_SEQ_CTRL_DIR_EN
      .dir      (dir),
`endif
      .count    (count),
      .pass_cnt (pass_cnt),
      .busy     (busy),
      .wrap     (wrap),
      .done     (done),
      .state    (state)
   );

   typedef struct {
      logic       rst_n, start, stop, pause;
      logic [3:0] limit, repeats;
      logic [3:0] count, pass;
      logic       busy, wrap, done;
      logic [1:0] state;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic s, input logic p_stop,
                               input logic p, input logic [3:0] l, input logic [3:0] rp,
                               input logic [3:0] c, input logic [3:0] pc, input logic b,
                               input logic w, input logic d, input logic [1:0] st);
      vec_t v;
      v.rst_n = r; v.start = s; v.stop = p_stop; v.pause = p;
      v.limit = l; v.repeats = rp;
      v.count = c; v.pass = pc; v.busy = b; v.wrap = w; v.done = d; v.state = st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   vec_t vt[16];
   int   nwrap, ndone, done_at;

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      limit = 4'd0; repeats = 4'd0; dir = 1'b0;

      //          rst st sp pa lim rep  cnt pass busy wrap done state
      vt[0]  = mk(0, 0, 0, 0, 4, 2,   0, 0, 0, 0, 0, 0);
      vt[1]  = mk(1, 0, 0, 0, 4, 2,   0, 0, 0, 0, 0, 0);
      vt[2]  = mk(1, 1, 0, 0, 4, 2,   0, 0, 1, 0, 0, 1);
      vt[3]  = mk(1, 0, 0, 0, 1, 5,   1, 0, 1, 0, 0, 1);
      vt[4]  = mk(1, 0, 0, 0, 1, 5,   2, 0, 1, 0, 0, 1);
      vt[5]  = mk(1, 1, 0, 0, 4, 2,   3, 0, 1, 0, 0, 1);
      vt[6]  = mk(1, 0, 0, 0, 4, 2,   4, 0, 1, 0, 0, 1);
      vt[7]  = mk(1, 0, 0, 0, 4, 2,   0, 1, 1, 1, 0, 1);
      vt[8]  = mk(1, 0, 0, 0, 4, 2,   1, 1, 1, 0, 0, 1);
      vt[9]  = mk(1, 0, 0, 0, 4, 2,   2, 1, 1, 0, 0, 1);
      vt[10] = mk(1, 0, 0, 0, 4, 2,   3, 1, 1, 0, 0, 1);
      vt[11] = mk(1, 0, 0, 0, 4, 2,   4, 1, 1, 0, 0, 1);
      vt[12] = mk(1, 0, 0, 0, 4, 2,   0, 2, 0, 1, 1, 3);
      vt[13] = mk(1, 0, 0, 0, 4, 2,   0, 2, 0, 0, 0, 0);
      vt[14] = mk(1, 1, 1, 0, 4, 2,   0, 2, 0, 0, 0, 0);
      vt[15] = mk(1, 0, 0, 0, 4, 2,   0, 2, 0, 0, 0, 0);

      #2;
      for (int i = 0; i < 16; i++) begin
         rst_n = vt[i].rst_n; start = vt[i].start; stop = vt[i].stop;
         pause = vt[i].pause; limit = vt[i].limit; repeats = vt[i].repeats;
         tick();
         chk($sformatf("v%0d count", i), 32'(count),    32'(vt[i].count));
         chk($sformatf("v%0d pass",  i), 32'(pass_cnt), 32'(vt[i].pass));
         chk($sformatf("v%0d busy",  i), 32'(busy),     32'(vt[i].busy));
         chk($sformatf("v%0d wrap",  i), 32'(wrap),     32'(vt[i].wrap));
         chk($sformatf("v%0d done",  i), 32'(done),     32'(vt[i].done));
         chk($sformatf("v%0d state", i), 32'(state),    32'(vt[i].state));
      end
      start = 1'b0; stop = 1'b0;

      // free-run with limit 3, then stop
      limit = 4'd3; repeats = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("free start state", 32'(state), 32'd1);
      nwrap = 0; ndone = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (wrap) nwrap++;
         if (done) ndone++;
      end
      chk("free wraps", 32'(nwrap), 32'd5);
      chk("free dones", 32'(ndone), 32'd0);
      chk("free pass", 32'(pass_cnt), 32'd5);
      chk("free last wrap", 32'(wrap), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop state", 32'(state), 32'd0);
      chk("stop count", 32'(count), 32'd0);
      chk("stop pass", 32'(pass_cnt), 32'd0);
      chk("stop done", 32'(done), 32'd0);
      chk("stop wrap", 32'(wrap), 32'd0);
      chk("stop busy", 32'(busy), 32'd0);

      // pause for three edges at count 2 delays done by three cycles
      limit = 4'd7; repeats = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("pre-pause count", 32'(count), 32'd2);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("hold%0d count", i), 32'(count), 32'd2);
         chk($sformatf("hold%0d state", i), 32'(state), 32'd2);
         chk($sformatf("hold%0d busy", i), 32'(busy), 32'd1);
      end
      pause = 1'b0;
      done_at = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done) begin
            done_at = k;
            break;
         end
      end
      chk("pause done delay", 32'(done_at), 32'd6);
      chk("pause done state", 32'(state), 32'd3);
      chk("pause done pass", 32'(pass_cnt), 32'd1);
      tick();
      chk("pause idle", 32'(state), 32'd0);

      // reset mid-run aborts with no done
      limit = 4'd9; repeats = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre-reset count", 32'(count), 32'd5);
      rst_n = 1'b0;
      tick();
      chk("rst count", 32'(count), 32'd0);
      chk("rst state", 32'(state), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst pass", 32'(pass_cnt), 32'd0);
      chk("rst wrap", 32'(wrap), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      rst_n = 1'b1;

      // limit 0: wrap every cycle, done with the third
      limit = 4'd0; repeats = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      chk("lim0 start state", 32'(state), 32'd1);
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk($sformatf("lim0 e%0d count", e), 32'(count), 32'd0);
         chk($sformatf("lim0 e%0d wrap", e), 32'(wrap), 32'd1);
         chk($sformatf("lim0 e%0d pass", e), 32'(pass_cnt), 32'(e));
         chk($sformatf("lim0 e%0d done", e), 32'(done), 32'(e == 3));
      end
      chk("lim0 end state", 32'(state), 32'd3);
      tick();
      chk("lim0 idle", 32'(state), 32'd0);

`ifdef COUNTER_SEQ_CTRL_DIR_EN
      // down counting: 3,2,1,0 then reload 3 with wrap and done
      dir = 1'b1; limit = 4'd3; repeats = 4'd1; start = 1'b1;
      tick();
      start = 1'b0; dir = 1'b0;
      chk("dn load count", 32'(count), 32'd3);
      for (int v = 2; v >= 0; v--) begin
         tick();
         chk($sformatf("dn count %0d", v), 32'(count), 32'(v));
         chk($sformatf("dn wrap %0d", v), 32'(wrap), 32'd0);
      end
      tick();
      chk("dn reload count", 32'(count), 32'd3);
      chk("dn wrap", 32'(wrap), 32'd1);
      chk("dn done", 32'(done), 32'd1);
      chk("dn state", 32'(state), 32'd3);
      chk("dn busy", 32'(busy), 32'd0);
      tick();
      chk("dn idle state", 32'(state), 32'd0);
      chk("dn idle count", 32'(count), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
